// File: rtl/commit_log_sched.sv
// Dual-slot commit scheduler: two records in, one record out per cycle, in program order.
// One cycle from push to log_valid_o; core is throttled by stall_o, or overflow is dropped and counted.
package drac_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] result;
   } commit_data_t;
endpackage

module commit_log_sched #(
   parameter int DEPTH        = 8,
   parameter bit DROP_ON_FULL = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable_i,
   input  logic                               flush_i,
   input  logic                               commit_valid_0_i,
   input  drac_pkg::commit_data_t             commit_data_0_i,
   input  logic                               commit_valid_1_i,
   input  drac_pkg::commit_data_t             commit_data_1_i,
   output logic                               stall_o,
   output logic                               log_valid_o,
   output drac_pkg::commit_data_t             log_data_o,
   input  logic                               log_ready_i,
   output logic [$clog2(DEPTH):0]             count_o,
   output logic [15:0]                        dropped_o,
   output logic                               idle_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   drac_pkg::commit_data_t mem [DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_1;
   logic [CW-1:0] count, free;
   logic [15:0]   drop_cnt;
   logic [16:0]   drop_sum;
   logic          accept, req0, req1, push0, push1, pop;
   logic [1:0]    n_req, n_push, n_drop;

   // Free space comes from the registered count only, so a same-cycle pop never makes room.
   always_comb begin
      free     = DEPTH_C - count;
      accept   = enable_i & ~flush_i;
      req0     = accept & commit_valid_0_i;
      req1     = accept & commit_valid_1_i;
      push0    = req0 & (free != '0);
      push1    = req1 & (push0 ? (free >= CW'(2)) : (free != '0));
      n_req    = {1'b0, req0} + {1'b0, req1};
      n_push   = {1'b0, push0} + {1'b0, push1};
      n_drop   = n_req - n_push;
      pop      = (count != '0) & log_ready_i & ~flush_i;
      wr_ptr_1 = wr_ptr + PW'(1);
      drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
   end

   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr] <= commit_data_0_i;
      if (push1) mem[push0 ? wr_ptr_1 : wr_ptr] <= commit_data_1_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(n_push);
         count  <= count + CW'(n_push) - CW'(pop);
         if (n_drop != 2'd0) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   assign stall_o     = DROP_ON_FULL ? 1'b0 : (free < CW'(2));
   assign log_valid_o = (count != '0);
   assign log_data_o  = log_valid_o ? mem[rd_ptr] : '0;
   assign count_o     = count;
   assign dropped_o   = drop_cnt;
   assign idle_o      = (count == '0);
endmodule

// File: tb/tb_commit_log_sched.sv
// Directed bench: one backpressure instance and one lossy instance share the same stimulus.
module tb_commit_log_sched;
   import drac_pkg::*;

   logic clk, rst, enable, flush, v0, v1, ready;
   commit_data_t d0, d1;

   logic         b_stall, b_lv, b_idle, l_stall, l_lv, l_idle;
   commit_data_t b_ld, l_ld;
   logic [3:0]   b_cnt, l_cnt;
   logic [15:0]  b_drop, l_drop;

   int n_vec = 0;
   int n_err = 0;

   commit_log_sched #(.DEPTH(8), .DROP_ON_FULL(1'b0)) u_bp (
      .clk(clk), .rst(rst), .enable_i(enable), .flush_i(flush),
      .commit_valid_0_i(v0), .commit_data_0_i(d0),
      .commit_valid_1_i(v1), .commit_data_1_i(d1),
      .stall_o(b_stall), .log_valid_o(b_lv), .log_data_o(b_ld),
      .log_ready_i(ready), .count_o(b_cnt), .dropped_o(b_drop), .idle_o(b_idle)
   );

   commit_log_sched #(.DEPTH(8), .DROP_ON_FULL(1'b1)) u_ls (
      .clk(clk), .rst(rst), .enable_i(enable), .flush_i(flush),
      .commit_valid_0_i(v0), .commit_data_0_i(d0),
      .commit_valid_1_i(v1), .commit_data_1_i(d1),
      .stall_o(l_stall), .log_valid_o(l_lv), .log_data_o(l_ld),
      .log_ready_i(ready), .count_o(l_cnt), .dropped_o(l_drop), .idle_o(l_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic commit_data_t mk(input int k);
      commit_data_t r;
      r.pc     = 32'h8000_0000 + 32'(k * 4);
      r.inst   = 32'h0000_0013 ^ 32'(k << 7);
      r.rd     = 5'(k + 1);
      r.we     = k[0];
      r.result = 32'hA5A5_0000 + 32'(k);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input int ka, input logic b, input int kb);
      v0 = a; d0 = mk(ka);
      v1 = b; d1 = mk(kb);
   endtask

   task automatic idle_in();
      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1; flush = 1'b0; ready = 1'b0;
      idle_in();
      tick();
      chk("rst_stall", b_stall, 1'b0);
      chk("rst_valid", b_lv, 1'b0);
      chk("rst_data",  b_ld, '0);
      chk("rst_count", b_cnt, 4'd0);
      chk("rst_drop",  b_drop, 16'd0);
      chk("rst_idle",  b_idle, 1'b1);
      rst = 1'b1;

      // single stream A,B,C through slot 0
      ready = 1'b1;
      drive(1, 1, 0, 0); tick();
      chk("ss_a_valid", b_lv, 1'b1);
      chk("ss_a_data", b_ld, mk(1));
      drive(1, 2, 0, 0); tick();
      chk("ss_b_data", b_ld, mk(2));
      chk("ss_b_count", b_cnt, 4'd1);
      drive(1, 3, 0, 0); tick();
      chk("ss_c_data", b_ld, mk(3));
      idle_in(); tick();
      chk("ss_idle", b_idle, 1'b1);
      chk("ss_empty_data", b_ld, '0);

      // dual slot ordering, then slot 1 alone
      drive(1, 10, 1, 11); tick();
      chk("dual_x", b_ld, mk(10));
      chk("dual_cnt2", b_cnt, 4'd2);
      idle_in(); tick();
      chk("dual_y", b_ld, mk(11));
      chk("dual_cnt1", b_cnt, 4'd1);
      drive(0, 0, 1, 12); tick();
      chk("slot1_z", b_ld, mk(12));
      chk("slot1_cnt", b_cnt, 4'd1);
      idle_in(); tick();
      chk("slot1_drain", b_cnt, 4'd0);

      // backpressure with logger stalled; R0..R7 land at FIFO offsets 0..7
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 20 + 2 * i, 1, 21 + 2 * i); tick();
      end
      chk("bp_cnt6", b_cnt, 4'd6);
      chk("bp_stall6", b_stall, 1'b0);
      drive(1, 26, 0, 0); tick();
      chk("bp_stall7", b_stall, 1'b1);
      chk("bp_head7", b_ld, mk(20));
      drive(1, 27, 0, 0); tick();
      chk("bp_cnt8", b_cnt, 4'd8);
      chk("bp_stall8", b_stall, 1'b1);
      chk("bp_head8", b_ld, mk(20));
      chk("ls_stall8", l_stall, 1'b0);
      idle_in(); ready = 1'b1; tick();
      chk("bp_pop1_cnt", b_cnt, 4'd7);
      chk("bp_pop1_stall", b_stall, 1'b1);
      chk("bp_pop1_head", b_ld, mk(21));
      tick();
      chk("bp_pop2_stall", b_stall, 1'b0);
      chk("bp_pop2_head", b_ld, mk(22));
      ready = 1'b0;
      drive(1, 28, 1, 29); tick();
      chk("bp_refill", b_cnt, 4'd8);
      chk("bp_nodrop", b_drop, 16'd0);
      drive(1, 30, 1, 31); tick();
      chk("bp_violate_cnt", b_cnt, 4'd8);
      chk("bp_violate_drop", b_drop, 16'd2);
      chk("bp_violate_head", b_ld, mk(22));

      // flush with a pair and a pop in the same cycle
      idle_in(); ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("fl_cnt5", b_cnt, 4'd5);
      chk("fl_head5", b_ld, mk(25));
      flush = 1'b1; drive(1, 40, 1, 41); tick();
      flush = 1'b0; idle_in();
      chk("fl_cnt", b_cnt, 4'd0);
      chk("fl_valid", b_lv, 1'b0);
      chk("fl_drop", b_drop, 16'd2);
      drive(1, 42, 0, 0); tick();
      chk("fl_ptr_w", b_ld, mk(42));
      enable = 1'b0; drive(1, 43, 1, 44); tick();
      chk("en0_cnt_a", b_cnt, 4'd0);
      tick();
      chk("en0_cnt_b", b_cnt, 4'd0);
      chk("en0_drop", b_drop, 16'd2);
      enable = 1'b1;

      // asynchronous reset between edges
      ready = 1'b0;
      drive(1, 50, 1, 51); tick();
      drive(1, 52, 0, 0); tick();
      idle_in();
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", b_lv, 1'b0);
      chk("ar_data", b_ld, '0);
      chk("ar_count", b_cnt, 4'd0);
      chk("ar_drop", b_drop, 16'd0);
      chk("ar_idle", b_idle, 1'b1);
      tick();
      rst = 1'b1; ready = 1'b1;
      tick();
      chk("ar_stale", b_lv, 1'b0);

      // lossy mode
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 60 + 2 * i, 1, 61 + 2 * i); tick();
      end
      drive(1, 66, 0, 0); tick();
      chk("ls_cnt7", l_cnt, 4'd7);
      drive(1, 70, 1, 71); tick();
      chk("ls_pq_cnt", l_cnt, 4'd8);
      chk("ls_pq_drop", l_drop, 16'd1);
      chk("ls_pq_stall", l_stall, 1'b0);
      drive(1, 72, 1, 73); tick();
      chk("ls_full_drop", l_drop, 16'd3);
      idle_in(); ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("ls_p_stored", l_ld, mk(70));
      chk("ls_p_cnt", l_cnt, 4'd1);
      tick();
      chk("ls_q_gone", l_lv, 1'b0);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 80, 1, 81); tick();
      end
      chk("ls_refill", l_cnt, 4'd8);
      for (int i = 0; i < 32767; i++) tick();
      chk("ls_sat", l_drop, 16'hFFFF);
      tick();
      chk("ls_sat_hold", l_drop, 16'hFFFF);
      idle_in();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/commit_log_sched.md
# commit_log_sched

Scheduler between the core's dual-ported commit/writeback outputs and the single-ported commit logger. Accepts up to two commit records per cycle, buffers them in program order in a circular FIFO, and presents them one per cycle on a valid/ready stream to the logger. Provides core backpressure, a flush, an enable gate and a saturating drop counter for lossy mode.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- DROP_ON_FULL, 0, 0 = backpressure core via stall_o; 1 = never stall, discard records that do not fit

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable_i  in  1  1 = accept commits; 0 = ignore inputs, keep draining
- flush_i  in  1  discard all buffered and same-cycle records
- commit_valid_0_i  in  1  older commit slot valid
- commit_data_0_i  in  $bits(commit_data_t)  older commit record (drac_pkg::commit_data_t)
- commit_valid_1_i  in  1  younger commit slot valid
- commit_data_1_i  in  $bits(commit_data_t)  younger commit record
- stall_o  out  1  core must not present commits this cycle
- log_valid_o  out  1  log_data_o holds a record
- log_data_o  out  $bits(commit_data_t)  head-of-FIFO record
- log_ready_i  in  1  logger consumes head this cycle
- count_o  out  $clog2(DEPTH)+1  occupied entries
- dropped_o  out  16  records discarded, saturates at 0xFFFF
- idle_o  out  1  count_o == 0

## Operation

- Storage: DEPTH-entry array, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, count register 0..DEPTH.
- Push set per cycle (enable_i=1, flush_i=0): slot 0 then slot 1, only valid slots. Slot 1 alone is legal and occupies one entry. Order in FIFO always slot 0 before slot 1.
- Free slots = DEPTH − count (registered value; same-cycle pop gives no credit).
- DROP_ON_FULL=0: stall_o = (free < 2). Core presenting commits while stall_o=1 is a protocol violation; RTL must still not overwrite: excess records dropped and counted exactly as in lossy mode.
- DROP_ON_FULL=1: stall_o tied 0. If 2 records, 1 free: slot 0 stored, slot 1 dropped. If 0 free: all dropped. dropped_o += number dropped, saturating.
- Pop: log_valid_o & log_ready_i → rd_ptr+1, head advances next cycle.
- Simultaneous push/pop: count_next = count + pushes − pop; both legal in same cycle incl. count=DEPTH with pop (push still limited by registered free).
- log_valid_o = (count ≠ 0); log_data_o = array[rd_ptr], held stable while log_valid_o & !log_ready_i.
- flush_i: highest priority. Next cycle count=0, rd_ptr=wr_ptr=0, log_valid_o=0; same-cycle pushes and pop ignored; dropped_o unchanged (flush is not a drop).
- enable_i=0: no pushes, no drops counted; pops continue.
- Reset mid-operation: all content lost immediately, no record emitted afterwards.

## Timing

- Reset values: stall_o=0, log_valid_o=0, log_data_o=0, count_o=0, dropped_o=0, idle_o=1; array contents don't-care but log_data_o forced 0 when empty.
- Latency: record pushed at edge N is visible on log_valid_o/log_data_o after edge N when FIFO was empty (one cycle).
- Throughput: 2 records/cycle in, 1 record/cycle out.
- stall_o, log_valid_o, idle_o, count_o are combinational only from registers (no input-to-output paths).
- log_ready_i affects state only; it never changes outputs in the same cycle.

## Test plan

- Single stream: DEPTH=8, log_ready_i=1, slot 0 only records A,B,C on cycles 1-3 → log_data_o = A,B,C on cycles 2-4, idle_o high from cycle 5.
- Dual commit ordering: cycle 1 slot0=X, slot1=Y, log_ready_i=1 → X cycle 2, Y cycle 3; slot1-only Z → Z next out, count_o never exceeds 2.
- Backpressure: log_ready_i=0, push pairs until count_o=7 → stall_o=1 at count 7 and 8; after one pop with no push, count 7, stall_o stays 1; after 2 pops stall_o=0; head held stable throughout.
- Lossy: DROP_ON_FULL=1, count=7, push pair P,Q → P stored, Q dropped, dropped_o=1; at count=8 push pair → dropped_o=3; force 0xFFFF → stays 0xFFFF.
- Flush and enable: count=5, flush_i with pair pushed and log_ready_i=1 → next cycle count_o=0, log_valid_o=0, dropped_o unchanged; enable_i=0 with valid commits → count_o stays 0.
- Async reset: assert rst low mid-transfer between edges → outputs at reset values immediately, no stale record after release.
